// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped GPIO: synchronised/debounced switches, LED and 7-seg registers, edge capture, masked irq.
// Latency: writes land on the next CLK edge; reads are combinational; a switch change reaches IN DEB_CYCLES+2 edges after it is first sampled.
// Backpressure: none; the bus is always ready and every selected access completes in the cycle it is presented.
//
// Ports: CLK/RST_N (async active-low), bus_sel/bus_we/bus_addr/bus_wdata/bus_rdata (word-offset register bus),
//        DIN_SW (raw switches), DOUT_LD (LEDs), DOUT_7S (hex nibbles, digit 0 in [3:0]), irq (registered).
// Register map: 0 IN, 1 LED, 2 SEG, 3 EDGE (W1C), 4 IRQ_EN, 5 LED_SET, 6 LED_CLR, 7 reserved/BLINK.
// Optional build macro GPIO_BLINK_EN: offset 7 becomes BLINK and a free-running phase masks the blinking LEDs.

module gpio_mmio_ctrl #(
    parameter int DIN_W      = 16,
    parameter int DOUT_W     = 16,
    parameter int NDIGITS    = 4,
    parameter int DEB_CYCLES = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   bus_sel,
    input  logic                   bus_we,
    input  logic [2:0]             bus_addr,
    input  logic [31:0]            bus_wdata,
    output logic [31:0]            bus_rdata,
    input  logic [DIN_W-1:0]       DIN_SW,
    output logic [DOUT_W-1:0]      DOUT_LD,
    output logic [4*NDIGITS-1:0]   DOUT_7S,
    output logic                   irq
);

    localparam int SEG_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [DIN_W-1:0]  sync_a, sync_b;
    logic [DIN_W-1:0]  in_q, in_d;
    logic [CNT_W-1:0]  deb_cnt [DIN_W];
    logic [CNT_W-1:0]  cnt_d   [DIN_W];
    logic [DOUT_W-1:0] led_q, led_d;
    logic [SEG_W-1:0]  seg_q;
    logic [DIN_W-1:0]  edge_q, edge_d, w1c_mask;
    logic [DIN_W-1:0]  irq_en_q;

    logic wr, rd;
    assign wr = bus_sel & bus_we;
    assign rd = bus_sel & ~bus_we;

    // Debounce: the counter runs only while the synchronised bit disagrees
    // with the debounced bit. For a single bit, "synchronised bit changed"
    // while disagreeing implies it now agrees, so one compare covers both
    // counter-reset conditions.
    always_comb begin
        in_d = in_q;
        for (int i = 0; i < DIN_W; i++) begin
            cnt_d[i] = '0;
            if (sync_b[i] != in_q[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    in_d[i] = sync_b[i];
                end else begin
                    cnt_d[i] = deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising debounced edges are ORed in after the W1C so a same-edge set wins.
    assign w1c_mask = (wr && bus_addr == 3'd3) ? bus_wdata[DIN_W-1:0] : '0;
    assign edge_d   = (edge_q & ~w1c_mask) | (in_d & ~in_q);

    always_comb begin
        led_d = led_q;
        if (wr) begin
            case (bus_addr)
                3'd1:    led_d = bus_wdata[DOUT_W-1:0];
                3'd5:    led_d = led_q | bus_wdata[DOUT_W-1:0];
                3'd6:    led_d = led_q & ~bus_wdata[DOUT_W-1:0];
                default: led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_a   <= '0;
            sync_b   <= '0;
            in_q     <= '0;
            led_q    <= '0;
            seg_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < DIN_W; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_a <= DIN_SW;
            sync_b <= sync_a;
            in_q   <= in_d;
            for (int i = 0; i < DIN_W; i++) begin
                deb_cnt[i] <= cnt_d[i];
            end
            led_q  <= led_d;
            edge_q <= edge_d;
            if (wr && bus_addr == 3'd2) seg_q    <= bus_wdata[SEG_W-1:0];
            if (wr && bus_addr == 3'd4) irq_en_q <= bus_wdata[DIN_W-1:0];
            // Built from the pre-edge EDGE/IRQ_EN, hence one cycle behind them.
            irq <= |(edge_q & irq_en_q);
        end
    end

`ifdef GPIO_BLINK_EN
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_DIV - 1);

    logic [DOUT_W-1:0] blink_q, blink_d, ld_q;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        blink_d = (wr && bus_addr == 3'd7) ? bus_wdata[DOUT_W-1:0] : blink_q;
        bcnt_d  = bcnt_q + BCNT_W'(1);
        phase_d = phase_q;
        if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // LED output is a flop fed from next-state values so it stays glitch-free
    // and still follows an LED write on the very next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_q <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            ld_q    <= '0;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            ld_q    <= led_d & ~(blink_d & {DOUT_W{phase_d}});
        end
    end

    assign DOUT_LD = ld_q;
`else
    assign DOUT_LD = led_q;
`endif

    assign DOUT_7S = seg_q;

    always_comb begin
        bus_rdata = '0;
        if (rd) begin
            case (bus_addr)
                3'd0:    bus_rdata[DIN_W-1:0]  = in_q;
                3'd1:    bus_rdata[DOUT_W-1:0] = led_q;
                3'd2:    bus_rdata[SEG_W-1:0]  = seg_q;
                3'd3:    bus_rdata[DIN_W-1:0]  = edge_q;
                3'd4:    bus_rdata[DIN_W-1:0]  = irq_en_q;
`ifdef GPIO_BLINK_EN
                3'd7:    bus_rdata[DOUT_W-1:0] = blink_q;
`endif
                default: bus_rdata = '0;
            endcase
        end
    end

endmodule
